// File: rtl/entropy_dec_pkg.sv
// Shared types and constants for the entropy decode scheduler.
// Holds the FSM state encoding and packet framing constants.
package entropy_dec_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        FETCH,
        ISSUE,
        OUTPUT,
        ABORT,
        DRAIN
    } state_e;

    localparam int BYTES_PER_SYM   = 3;
    localparam int TIMEOUT_CYC_DEF = 16;

    // States in which the byte stream is consumed.
    function automatic logic takes_bytes(input state_e s);
        return (s == IDLE) || (s == HDR) ||
               (s == FETCH) || (s == DRAIN);
    endfunction

endpackage

// File: rtl/sched_byte_assembler.sv
// Collects the code byte and 16-bit bitstream word of one symbol.
// done_o flags the cycle in which the final byte is accepted.
module sched_byte_assembler
    import entropy_dec_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [7:0]  byte_i,
    output logic [7:0]  code_o,
    output logic [15:0] bits_o,
    output logic        done_o
);

    logic [1:0]  idx_q;
    logic [7:0]  code_q;
    logic [15:0] bits_q;

    assign done_o = en_i && (idx_q == 2'(BYTES_PER_SYM - 1));
    assign code_o = code_q;
    assign bits_o = bits_q;

    // Steer each accepted byte into its field and advance the index.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q  <= '0;
            code_q <= '0;
            bits_q <= '0;
        end else if (clr_i) begin
            idx_q <= '0;
        end else if (en_i) begin
            case (idx_q)
                2'd0:    code_q        <= byte_i;
                2'd1:    bits_q[15:8]  <= byte_i;
                default: bits_q[7:0]   <= byte_i;
            endcase
            idx_q <= done_o ? 2'd0 : idx_q + 2'd1;
        end
    end

endmodule

// File: rtl/entropy_decode_scheduler.sv
// Packet-level sequencer wrapped around the LiDAR entropy decoder.
// Parses headers, issues symbols, forwards results, drains on abort.
module entropy_decode_scheduler
    import entropy_dec_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int CNT_W       = 16,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    input  logic                 in_sop,
    output logic                 in_ready,
    output logic                 dec_en,
    output logic [7:0]           dec_code,
    output logic [15:0]          dec_bits,
    input  logic [15:0]          dec_symbol,
    input  logic                 dec_valid,
    input  logic                 dec_error,
    output logic [15:0]          sym_data,
    output logic                 sym_valid,
    output logic                 sym_last,
    input  logic                 sym_ready,
    output logic                 pkt_done,
    output logic                 pkt_error,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 busy
);

    localparam int DW = CNT_W + 2;
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;

    state_e               state_q, state_d;
    logic [7:0]           hi_q;
    logic [CNT_W-1:0]     rem_q;
    logic [DW-1:0]        drain_q;
    logic [TW-1:0]        timer_q;
    logic [15:0]          sym_q;
    logic [ERR_CNT_W-1:0] err_q;
    logic                 rdy_q, en_q, sv_q, sl_q;
    logic                 done_q, perr_q, busy_q;

    logic                 acc, fetch_en, asm_done;
    logic                 timeout, abort_evt;
    logic [CNT_W-1:0]     hdr_cnt;
    logic [DW-1:0]        drain_calc;

    assign acc      = in_valid && rdy_q;
    assign fetch_en = acc && !in_sop && (state_q == FETCH);
    assign hdr_cnt  = CNT_W'({hi_q, in_data});
    assign timeout  = (timer_q == TW'(TIMEOUT_CYC - 1));

    // The whole current symbol was fetched before ISSUE.
    assign drain_calc = DW'(rem_q) * DW'(BYTES_PER_SYM)
                      - DW'(BYTES_PER_SYM);

    assign abort_evt = (state_q == ISSUE && state_d == ABORT) ||
                       (acc && in_sop &&
                        (state_q == HDR || state_q == FETCH));

    sched_byte_assembler u_asm (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .clr_i  (state_q != FETCH),
        .en_i   (fetch_en),
        .byte_i (in_data),
        .code_o (dec_code),
        .bits_o (dec_bits),
        .done_o (asm_done)
    );

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:
                if (acc && in_sop) state_d = HDR;
            HDR:
                if (acc) begin
                    if (in_sop)            state_d = HDR;
                    else if (hdr_cnt == 0) state_d = IDLE;
                    else                   state_d = FETCH;
                end
            FETCH:
                if (acc) begin
                    if (in_sop)        state_d = HDR;
                    else if (asm_done) state_d = ISSUE;
                end
            ISSUE:
                if (dec_error)      state_d = ABORT;
                else if (dec_valid) state_d = OUTPUT;
                else if (timeout)   state_d = ABORT;
            OUTPUT:
                if (sym_ready)
                    state_d = (rem_q == 1) ? IDLE : FETCH;
            ABORT:
                state_d = (drain_calc == 0) ? IDLE : DRAIN;
            DRAIN:
                if (acc) begin
                    if (in_sop)            state_d = HDR;
                    else if (drain_q <= 1) state_d = IDLE;
                end
            default:
                state_d = IDLE;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            hi_q    <= '0;
            rem_q   <= '0;
            drain_q <= '0;
            timer_q <= '0;
            sym_q   <= '0;
            err_q   <= '0;
            rdy_q   <= 1'b0;
            en_q    <= 1'b0;
            sv_q    <= 1'b0;
            sl_q    <= 1'b0;
            done_q  <= 1'b0;
            perr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= takes_bytes(state_d);
            busy_q  <= (state_d != IDLE);
            en_q    <= (state_d == ISSUE);
            sv_q    <= (state_d == OUTPUT);
            sl_q    <= (state_d == OUTPUT) && (rem_q == 1);
            done_q  <= 1'b0;
            perr_q  <= 1'b0;
            if (acc && in_sop) hi_q <= in_data;
            timer_q <= '0;
            case (state_q)
                HDR:
                    if (acc && !in_sop) begin
                        rem_q <= hdr_cnt;
                        if (hdr_cnt == 0) done_q <= 1'b1;
                    end
                ISSUE: begin
                    timer_q <= timer_q + 1'b1;
                    if (dec_valid && !dec_error) sym_q <= dec_symbol;
                end
                OUTPUT:
                    if (sym_ready) begin
                        if (rem_q != 0) rem_q <= rem_q - 1'b1;
                        if (rem_q == 1) done_q <= 1'b1;
                    end
                ABORT:
                    drain_q <= drain_calc;
                DRAIN:
                    if (acc && !in_sop && drain_q != 0)
                        drain_q <= drain_q - 1'b1;
                default: ;
            endcase
            if (abort_evt) begin
                perr_q <= 1'b1;
                if (err_q != '1) err_q <= err_q + 1'b1;
            end
        end
    end

    assign in_ready  = rdy_q;
    assign dec_en    = en_q;
    assign sym_data  = sym_q;
    assign sym_valid = sv_q;
    assign sym_last  = sl_q;
    assign pkt_done  = done_q;
    assign pkt_error = perr_q;
    assign err_count = err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_entropy_decode_scheduler.sv
// Directed self-checking bench for entropy_decode_scheduler.
// Linear stimulus with hand-computed expectations.
module tb_entropy_decode_scheduler;

    logic        clk;
    logic        reset_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_sop;
    logic        in_ready;
    logic        dec_en;
    logic [7:0]  dec_code;
    logic [15:0] dec_bits;
    logic [15:0] dec_symbol;
    logic        dec_valid;
    logic        dec_error;
    logic [15:0] sym_data;
    logic        sym_valid;
    logic        sym_last;
    logic        sym_ready;
    logic        pkt_done;
    logic        pkt_error;
    logic [7:0]  err_count;
    logic        busy;

    int vectors;
    int miscompares;

    entropy_decode_scheduler dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_sop     (in_sop),
        .in_ready   (in_ready),
        .dec_en     (dec_en),
        .dec_code   (dec_code),
        .dec_bits   (dec_bits),
        .dec_symbol (dec_symbol),
        .dec_valid  (dec_valid),
        .dec_error  (dec_error),
        .sym_data   (sym_data),
        .sym_valid  (sym_valid),
        .sym_last   (sym_last),
        .sym_ready  (sym_ready),
        .pkt_done   (pkt_done),
        .pkt_error  (pkt_error),
        .err_count  (err_count),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s: got %h want %h", tag, o, e);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic sop);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        chk("in_ready", 32'(in_ready), 1);
        in_data  = b;
        in_sop   = sop;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_sop   = 1'b0;
    endtask

    task automatic sym(input logic [7:0] c, input logic [15:0] b,
                       input logic [15:0] s, input logic last);
        send(c, 1'b0);
        send(b[15:8], 1'b0);
        send(b[7:0], 1'b0);
        chk("dec_en", 32'(dec_en), 1);
        chk("dec_code", 32'(dec_code), 32'(c));
        chk("dec_bits", 32'(dec_bits), 32'(b));
        chk("rdy_issue", 32'(in_ready), 0);
        tick();
        chk("dec_en_hold", 32'(dec_en), 1);
        dec_symbol = s;
        dec_valid  = 1'b1;
        tick();
        dec_valid  = 1'b0;
        chk("sym_valid", 32'(sym_valid), 1);
        chk("sym_data", 32'(sym_data), 32'(s));
        chk("sym_last", 32'(sym_last), 32'(last));
        chk("dec_en_off", 32'(dec_en), 0);
    endtask

    task automatic accept();
        sym_ready = 1'b1;
        tick();
        sym_ready = 1'b0;
        chk("sym_v_drop", 32'(sym_valid), 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        chk("rst_rdy", 32'(in_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err_count), 0);
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        int n;
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        in_data     = '0;
        in_valid    = 1'b0;
        in_sop      = 1'b0;
        dec_symbol  = '0;
        dec_valid   = 1'b0;
        dec_error   = 1'b0;
        sym_ready   = 1'b0;
        tick();
        chk("rst_dec_en", 32'(dec_en), 0);
        chk("rst_sym_v", 32'(sym_valid), 0);
        chk("rst_done", 32'(pkt_done), 0);
        chk("rst_perr", 32'(pkt_error), 0);
        do_reset();
        chk("idle_rdy", 32'(in_ready), 1);

        // 1: two-symbol packet
        send(8'h00, 1'b1);
        chk("hdr_busy", 32'(busy), 1);
        send(8'h02, 1'b0);
        sym(8'h11, 16'h1234, 16'h0005, 1'b0);
        accept();
        chk("fetch_rdy", 32'(in_ready), 1);
        sym(8'h22, 16'hABCD, 16'h0007, 1'b1);
        accept();
        chk("t1_done", 32'(pkt_done), 1);
        chk("t1_busy", 32'(busy), 0);
        tick();
        chk("t1_done_pulse", 32'(pkt_done), 0);
        chk("t1_err", 32'(err_count), 0);

        // 2: backpressure on symbol 1
        send(8'h00, 1'b1);
        send(8'h02, 1'b0);
        sym(8'h11, 16'h1234, 16'h0005, 1'b0);
        in_data  = 8'h99;
        in_valid = 1'b1;
        repeat (10) begin
            chk("bp_valid", 32'(sym_valid), 1);
            chk("bp_data", 32'(sym_data), 32'h0005);
            chk("bp_rdy", 32'(in_ready), 0);
            chk("bp_dec_en", 32'(dec_en), 0);
            tick();
        end
        in_valid = 1'b0;
        accept();
        sym(8'h22, 16'hABCD, 16'h0007, 1'b1);
        accept();
        chk("t2_done", 32'(pkt_done), 1);

        // 3: decoder error on symbol 2 (error wins over valid)
        do_reset();
        send(8'h00, 1'b1);
        send(8'h03, 1'b0);
        sym(8'h01, 16'h0203, 16'h0010, 1'b0);
        accept();
        send(8'h04, 1'b0);
        send(8'h05, 1'b0);
        send(8'h06, 1'b0);
        tick();
        dec_error  = 1'b1;
        dec_valid  = 1'b1;
        dec_symbol = 16'hDEAD;
        tick();
        dec_error = 1'b0;
        dec_valid = 1'b0;
        chk("t3_perr", 32'(pkt_error), 1);
        chk("t3_err", 32'(err_count), 1);
        chk("t3_no_sym", 32'(sym_valid), 0);
        chk("t3_dec_en", 32'(dec_en), 0);
        tick();
        chk("t3_perr_pulse", 32'(pkt_error), 0);
        send(8'hE0, 1'b0);
        send(8'hE1, 1'b0);
        chk("t3_drain_busy", 32'(busy), 1);
        send(8'hE2, 1'b0);
        chk("t3_drained", 32'(busy), 0);
        send(8'h00, 1'b1);
        send(8'h01, 1'b0);
        sym(8'h44, 16'h0102, 16'h00AA, 1'b1);
        accept();
        chk("t3_next_done", 32'(pkt_done), 1);
        chk("t3_err_keep", 32'(err_count), 1);

        // 4: decoder timeout
        do_reset();
        send(8'h00, 1'b1);
        send(8'h02, 1'b0);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        n = 0;
        while (dec_en && n < 40) begin
            n++;
            tick();
        end
        chk("t4_en_cycles", 32'(n), 16);
        chk("t4_perr", 32'(pkt_error), 1);
        chk("t4_err", 32'(err_count), 1);
        tick();
        send(8'hD0, 1'b0);
        send(8'hD1, 1'b0);
        chk("t4_drain_busy", 32'(busy), 1);
        send(8'hD2, 1'b0);
        chk("t4_drained", 32'(busy), 0);

        // 5: zero-symbol packet, stray bytes in IDLE
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        chk("t5_stray", 32'(busy), 0);
        send(8'h00, 1'b1);
        send(8'h00, 1'b0);
        chk("t5_done", 32'(pkt_done), 1);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_no_en", 32'(dec_en), 0);
        tick();
        chk("t5_pulse", 32'(pkt_done), 0);

        // 6: SOP inside FETCH restarts the packet
        do_reset();
        send(8'h00, 1'b1);
        send(8'h01, 1'b0);
        send(8'hAA, 1'b0);
        send(8'h00, 1'b1);
        chk("t6_perr", 32'(pkt_error), 1);
        chk("t6_err", 32'(err_count), 1);
        chk("t6_busy", 32'(busy), 1);
        send(8'h01, 1'b0);
        sym(8'h33, 16'h4455, 16'h0009, 1'b1);
        accept();
        chk("t6_done", 32'(pkt_done), 1);

        // 6b: error counter saturation
        do_reset();
        send(8'h00, 1'b1);
        repeat (255) send(8'h00, 1'b1);
        chk("sat_255", 32'(err_count), 32'hFF);
        send(8'h00, 1'b1);
        chk("sat_perr", 32'(pkt_error), 1);
        chk("sat_hold", 32'(err_count), 32'hFF);

        // 6c: asynchronous reset while in ISSUE
        send(8'h01, 1'b0);
        send(8'h10, 1'b0);
        send(8'h20, 1'b0);
        send(8'h30, 1'b0);
        chk("ar_en", 32'(dec_en), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_en_off", 32'(dec_en), 0);
        chk("ar_code", 32'(dec_code), 0);
        chk("ar_bits", 32'(dec_bits), 0);
        chk("ar_rdy", 32'(in_ready), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_err", 32'(err_count), 0);
        chk("ar_perr", 32'(pkt_error), 0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("ar_idle_rdy", 32'(in_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/entropy_decode_scheduler.md
Name: entropy_decode_scheduler

Overview:
Sequences the LiDAR entropy decoder (decode_en / encoded_data / bitstream → decoded_symbol / decode_valid / decode_error) for one packet at a time.
- Parses a byte-stream packet header giving the symbol count.
- Assembles each symbol's 8-bit code byte and 16-bit bitstream word.
- Holds the decoder enable until the decoder responds, then forwards symbols downstream under valid/ready backpressure.
- Handles decoder errors, timeouts and malformed packets by draining and flagging.

Parameters:
TIMEOUT_CYC, 16, max cycles dec_en stays high without dec_valid/dec_error before a timeout error
CNT_W, 16, width of the symbol-count field and remaining-symbol counter
ERR_CNT_W, 8, width of the saturating error counter

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
in_data  in  8  packet byte stream
in_valid  in  1  in_data valid
in_sop  in  1  marks first byte of a packet (qualified by in_valid)
in_ready  out  1  byte accepted when in_valid & in_ready
dec_en  out  1  decoder enable (to decode_en)
dec_code  out  8  to decoder encoded_data
dec_bits  out  16  to decoder bitstream
dec_symbol  in  16  decoder decoded_symbol
dec_valid  in  1  decoder decode_valid
dec_error  in  1  decoder decode_error
sym_data  out  16  decoded symbol
sym_valid  out  1  sym_data valid
sym_last  out  1  last symbol of packet (qualified by sym_valid)
sym_ready  in  1  downstream accept
pkt_done  out  1  one-cycle pulse: packet completed cleanly
pkt_error  out  1  one-cycle pulse: packet aborted
err_count  out  ERR_CNT_W  saturating count of aborted packets
busy  out  1  state != IDLE

Behaviour:
- Reset: every output is 0; state IDLE; counters 0. Reset mid-operation abandons the packet with no pulse.
- Byte packet format: SOP byte = count[15:8], then count[7:0], then per symbol 3 bytes: code, bits[15:8], bits[7:0].
- States:
  - IDLE: in_ready=1. Bytes without in_sop are discarded silently. Byte with in_sop → cnt_hi loaded → HDR.
  - HDR: in_ready=1. Next byte gives cnt_lo; remaining := {hi,lo}.
    - remaining==0 → pkt_done pulse next cycle → IDLE.
    - otherwise → FETCH, byte index 0.
  - FETCH: in_ready=1. Collect 3 bytes into code/bits registers. After the 3rd byte → ISSUE.
  - ISSUE: dec_en=1 with dec_code/dec_bits held stable; timer counts from 0.
    - dec_error=1 → ABORT. dec_error takes priority if asserted together with dec_valid.
    - else dec_valid=1 → latch dec_symbol; dec_en=0 next cycle → OUTPUT.
    - timer reaches TIMEOUT_CYC-1 with neither → ABORT.
  - OUTPUT: sym_valid=1, sym_data stable. sym_last=1 iff remaining==1.
    - On sym_ready: remaining−1. If it becomes 0 → pkt_done pulse → IDLE; else → FETCH.
    - sym_valid must not drop and sym_data must not change until accepted.
  - ABORT: pkt_error pulse one cycle; err_count+1, saturating at all-ones. Then → DRAIN with drain_bytes := remaining*3 − bytes already fetched for the current symbol.
  - DRAIN: in_ready=1; discard bytes until drain_bytes reaches 0 → IDLE.
- Protocol error: in_sop on an accepted byte in HDR, FETCH or DRAIN aborts the current packet (pkt_error, err_count+1, except no extra pulse if already in DRAIN). That byte is treated as the new packet's cnt_hi → HDR.
- in_ready=0 in ISSUE, OUTPUT and ABORT; no input is consumed there.
- Latency: last bitstream byte accepted → dec_en high next cycle. Decoder response → sym_valid next cycle.
- Arithmetic: drain count is 18 bits (CNT_W+2). Remaining counter never wraps; the decrement only occurs when remaining>0.

Decomposition:
- Shared package entropy_dec_pkg: state enum (IDLE, HDR, FETCH, ISSUE, OUTPUT, ABORT, DRAIN), BYTES_PER_SYM=3, default TIMEOUT_CYC.
- One natural sub-module, sched_byte_assembler: 3-byte collector with index counter, clear and done outputs, used in FETCH.
- FSM, timeout counter and error counter stay in the top module.

Test Plan:
1. Header 0x0002, symbols {0x11,0x12,0x34}, {0x22,0xAB,0xCD}; decoder model returns 0x0005 then 0x0007 after 2 cycles → dec_bits 0x1234 then 0xABCD; sym_data 0x0005 then 0x0007 (sym_last on 2nd); one pkt_done; err_count 0.
2. Same packet with sym_ready held low 10 cycles on symbol 1 → sym_valid/sym_data stable throughout; in_ready=0; no 2nd dec_en until accepted.
3. Header 0x0003; decoder asserts dec_error on symbol 2 → pkt_error pulse; err_count=1; exactly 3 further bytes drained; next SOP packet decodes normally.
4. Decoder never responds → dec_en deasserts after exactly 16 cycles; pkt_error; err_count=1; remaining bytes drained.
5. Header 0x0000 → pkt_done one cycle after 2nd byte; dec_en never asserted. Non-SOP bytes in IDLE are ignored.
6. in_sop arrives on 2nd byte of FETCH → pkt_error; that byte is parsed as new cnt_hi; the new packet completes. Also: force 255 errors then one more → err_count stays 0xFF; reset_n low mid-ISSUE → all outputs 0 immediately.
